// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared types and helpers for the single-clock FIFO slice.
//   fifo_mode_e    : read mode, FIFO_STD (registered read) / FIFO_FWFT
//   fifo_depth()   : entry count derived from the address width
//   fifo_level_w() : width of the occupancy count (must represent 0..DEPTH)
// ---------------------------------------------------------------------------
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int fifo_depth(input int asize);
    return 1 << asize;
  endfunction

  // One extra bit so that a completely full FIFO (level == DEPTH) is representable.
  function automatic int fifo_level_w(input int asize);
    return asize + 1;
  endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// ---------------------------------------------------------------------------
// fifo_ram_2p
// DEPTH x DSIZE storage: one synchronous write port, one asynchronous read
// port.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
// ---------------------------------------------------------------------------
module fifo_ram_2p
  import fifo_pkg::*;
#(
  parameter int DSIZE = 32,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ASIZE);

  logic [DSIZE-1:0] mem [DEPTH];

  // NOTE: storage has no reset; occupancy tracking guarantees no entry is read
  // before it is written, and a reset-free array maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_fwft.sv
// ---------------------------------------------------------------------------
// fifo_sync_fwft
// Single-clock FIFO with a standard (registered) or first-word-fall-through
// read, occupancy level, almost-full/almost-empty thresholds and flush.
// Optional build macro: FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
// flags cleared by clr_err; without it those outputs are tied low.
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   flush         : synchronous clear of contents (wins over winc/rinc)
//   wdata, winc   : write data / write request
//   wfull         : full flag
//   walmost_full  : level >= AFULL_THR
//   rinc          : read request (pop)
//   rdata         : read data (FWFT: head word while rempty=0)
//   rempty        : empty flag
//   ralmost_empty : level <= AEMPTY_THR
//   level         : stored word count, 0..DEPTH
//   overflow      : sticky, write attempted while full
//   underflow     : sticky, read attempted while empty
//   clr_err       : clears overflow/underflow
// ---------------------------------------------------------------------------
module fifo_sync_fwft
  import fifo_pkg::*;
#(
  parameter int DSIZE      = 32,
  parameter int ASIZE      = 4,
  parameter int FWFT       = 0,
  parameter int AFULL_THR  = fifo_depth(ASIZE) - 2,
  parameter int AEMPTY_THR = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   level,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam int         DEPTH = fifo_depth(ASIZE);
  localparam fifo_mode_e MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  typedef logic [fifo_level_w(ASIZE)-1:0] level_t;

  localparam level_t DEPTH_LV  = level_t'(DEPTH);
  localparam level_t AFULL_LV  = level_t'(AFULL_THR);
  localparam level_t AEMPTY_LV = level_t'(AEMPTY_THR);

  level_t           wbin, rbin;
  level_t           level_nxt;
  logic             wr_ok, rd_ok;
  logic [DSIZE-1:0] ram_q;

  // Both qualifiers use registered flags, so a write into a full FIFO is
  // dropped even when a pop happens in the same cycle.
  assign wr_ok = winc & ~wfull  & ~flush;
  assign rd_ok = rinc & ~rempty & ~flush;

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    level_nxt = level;
    if (flush) begin
      level_nxt = '0;
    end else if (wr_ok && !rd_ok) begin
      level_nxt = level + 1'b1;
    end else if (rd_ok && !wr_ok) begin
      level_nxt = level - 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin <= '0;
      rbin <= '0;
    end else if (flush) begin
      wbin <= '0;
      rbin <= '0;
    end else begin
      if (wr_ok) wbin <= wbin + 1'b1;
      if (rd_ok) rbin <= rbin + 1'b1;
    end
  end

  // Flags come from the next-state level, so they are valid right after the
  // edge with no extra cycle of latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level         <= '0;
      wfull         <= 1'b0;
      rempty        <= 1'b1;
      walmost_full  <= 1'b0;
      ralmost_empty <= 1'b1;
    end else begin
      level         <= level_nxt;
      wfull         <= (level_nxt == DEPTH_LV);
      rempty        <= (level_nxt == '0);
      walmost_full  <= (level_nxt >= AFULL_LV);
      ralmost_empty <= (level_nxt <= AEMPTY_LV);
    end
  end

  fifo_ram_2p #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wbin[ASIZE-1:0]),
    .wdata (wdata),
    .raddr (rbin[ASIZE-1:0]),
    .rdata (ram_q)
  );

  generate
    if (MODE == FIFO_FWFT) begin : g_fwft
      // Head word is shown directly; zero while empty keeps rdata defined
      // after reset/flush instead of exposing uninitialised storage.
      assign rdata = rempty ? '0 : ram_q;
    end else begin : g_std
      logic [DSIZE-1:0] rdata_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata_q <= '0;
        end else if (rd_ok) begin
          rdata_q <= ram_q;
        end
      end
      assign rdata = rdata_q;
    end
  endgenerate

`ifdef FIFO_ERR_FLAGS_EN
  // Error detection uses the raw requests: any attempt against a full/empty
  // FIFO is recorded, including attempts made during a flush cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr_err) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc & wfull)  overflow  <= 1'b1;
      if (rinc & rempty) underflow <= 1'b1;
    end
  end
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// ---------------------------------------------------------------------------
// tb_fifo_sync_fwft
// Drives one stimulus stream into a standard-read instance (u_std) and a
// first-word-fall-through instance (u_fwft) of fifo_sync_fwft, DEPTH=4,
// AFULL_THR=3, AEMPTY_THR=1. Inputs change 1 time unit after the rising edge
// and outputs are sampled there too, away from the active edge.
// ---------------------------------------------------------------------------
module tb_fifo_sync_fwft;

  localparam int DSIZE = 32;
  localparam int ASIZE = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic [DSIZE-1:0] wdata = '0;
  logic             winc = 1'b0;
  logic             rinc = 1'b0;
  logic             clr_err = 1'b0;

  logic             s_wfull, s_walmost_full, s_rempty, s_ralmost_empty, s_overflow, s_underflow;
  logic [DSIZE-1:0] s_rdata;
  logic [ASIZE:0]   s_level;

  logic             f_wfull, f_walmost_full, f_rempty, f_ralmost_empty, f_overflow, f_underflow;
  logic [DSIZE-1:0] f_rdata;
  logic [ASIZE:0]   f_level;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_sync_fwft #(
    .DSIZE(DSIZE), .ASIZE(ASIZE), .FWFT(0), .AFULL_THR(3), .AEMPTY_THR(1)
  ) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wdata(wdata), .winc(winc),
    .wfull(s_wfull), .walmost_full(s_walmost_full), .rinc(rinc),
    .rdata(s_rdata), .rempty(s_rempty), .ralmost_empty(s_ralmost_empty),
    .level(s_level), .overflow(s_overflow), .underflow(s_underflow),
    .clr_err(clr_err)
  );

  fifo_sync_fwft #(
    .DSIZE(DSIZE), .ASIZE(ASIZE), .FWFT(1), .AFULL_THR(3), .AEMPTY_THR(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wdata(wdata), .winc(winc),
    .wfull(f_wfull), .walmost_full(f_walmost_full), .rinc(rinc),
    .rdata(f_rdata), .rempty(f_rempty), .ralmost_empty(f_ralmost_empty),
    .level(f_level), .overflow(f_overflow), .underflow(f_underflow),
    .clr_err(clr_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    total += 6;
    if (s_level !== 3'd0)       begin bad++; $display("FAIL reset_level: got %0d want 0", s_level); end
    if (s_rempty !== 1'b1)      begin bad++; $display("FAIL reset_rempty: got %b want 1", s_rempty); end
    if (s_wfull !== 1'b0)       begin bad++; $display("FAIL reset_wfull: got %b want 0", s_wfull); end
    if ({s_walmost_full, s_ralmost_empty} !== 2'b01)
                                begin bad++; $display("FAIL reset_almost: got %b want 01", {s_walmost_full, s_ralmost_empty}); end
    if (s_rdata !== 32'h0)      begin bad++; $display("FAIL reset_rdata: got %h want 0", s_rdata); end
    if ({s_overflow, s_underflow} !== 2'b00)
                                begin bad++; $display("FAIL reset_err: got %b want 00", {s_overflow, s_underflow}); end
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_fill();
    logic [ASIZE:0] exp_lvl [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic           exp_af  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic           exp_ful [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic           exp_ae  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      winc  = 1'b1;
      wdata = 32'hA0 + i;
      step();
      total += 4;
      if (s_level !== exp_lvl[i])     begin bad++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, s_level, exp_lvl[i]); end
      if (s_walmost_full !== exp_af[i]) begin bad++; $display("FAIL fill_afull[%0d]: got %b want %b", i, s_walmost_full, exp_af[i]); end
      if (s_wfull !== exp_ful[i])     begin bad++; $display("FAIL fill_wfull[%0d]: got %b want %b", i, s_wfull, exp_ful[i]); end
      if (s_ralmost_empty !== exp_ae[i]) begin bad++; $display("FAIL fill_aempty[%0d]: got %b want %b", i, s_ralmost_empty, exp_ae[i]); end
    end
    // Write while full must be dropped.
    wdata = 32'hFF;
    step();
    winc = 1'b0;
    total += 3;
    if (s_level !== 3'd4)     begin bad++; $display("FAIL full_write_level: got %0d want 4", s_level); end
    if (s_wfull !== 1'b1)     begin bad++; $display("FAIL full_write_wfull: got %b want 1", s_wfull); end
    if (f_rdata !== 32'hA0)   begin bad++; $display("FAIL fwft_head_full: got %h want a0", f_rdata); end
  endtask

  task automatic test_drain_std();
    for (int i = 0; i < 4; i++) begin
      rinc = 1'b1;
      step();
      total += 2;
      if (s_rdata !== 32'hA0 + i)  begin bad++; $display("FAIL drain_rdata[%0d]: got %h want %h", i, s_rdata, 32'hA0 + i); end
      if (s_level !== 3'(3 - i))   begin bad++; $display("FAIL drain_level[%0d]: got %0d want %0d", i, s_level, 3 - i); end
    end
    total += 1;
    if (s_rempty !== 1'b1) begin bad++; $display("FAIL drain_rempty: got %b want 1", s_rempty); end
    // Read while empty: ignored, rdata holds.
    step();
    rinc = 1'b0;
    total += 2;
    if (s_rdata !== 32'hA3) begin bad++; $display("FAIL empty_read_rdata: got %h want a3", s_rdata); end
    if (s_level !== 3'd0)   begin bad++; $display("FAIL empty_read_level: got %0d want 0", s_level); end
  endtask

  task automatic test_fwft();
    winc  = 1'b1;
    wdata = 32'h11;
    step();
    winc  = 1'b0;
    total += 3;
    if (f_rempty !== 1'b0)   begin bad++; $display("FAIL fwft_rempty: got %b want 0", f_rempty); end
    if (f_rdata !== 32'h11)  begin bad++; $display("FAIL fwft_rdata: got %h want 11", f_rdata); end
    if (s_rdata !== 32'hA3)  begin bad++; $display("FAIL std_hold: got %h want a3", s_rdata); end
    rinc = 1'b1;
    step();
    rinc = 1'b0;
    total += 2;
    if (f_rempty !== 1'b1)   begin bad++; $display("FAIL fwft_pop_rempty: got %b want 1", f_rempty); end
    if (s_rdata !== 32'h11)  begin bad++; $display("FAIL std_pop_rdata: got %h want 11", s_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [DSIZE-1:0] q [$];
    logic [DSIZE-1:0] exp;
    for (int i = 0; i < 2; i++) begin
      winc  = 1'b1;
      wdata = 32'hB0 + i;
      q.push_back(wdata);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      rinc  = 1'b1;
      wdata = 32'hC0 + i;
      total += 1;
      if (f_rdata !== q[0]) begin bad++; $display("FAIL b2b_fwft_head[%0d]: got %h want %h", i, f_rdata, q[0]); end
      q.push_back(wdata);
      exp = q.pop_front();
      step();
      total += 2;
      if (s_level !== 3'd2)  begin bad++; $display("FAIL b2b_level[%0d]: got %0d want 2", i, s_level); end
      if (s_rdata !== exp)   begin bad++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, s_rdata, exp); end
    end
    winc = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp = q.pop_front();
      step();
      total += 1;
      if (s_rdata !== exp) begin bad++; $display("FAIL b2b_tail[%0d]: got %h want %h", i, s_rdata, exp); end
    end
    rinc = 1'b0;
    total += 1;
    if (s_rempty !== 1'b1) begin bad++; $display("FAIL b2b_rempty: got %b want 1", s_rempty); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      winc  = 1'b1;
      wdata = 32'hD0 + i;
      step();
    end
    flush = 1'b1;
    winc  = 1'b1;
    rinc  = 1'b1;
    wdata = 32'hEE;
    step();
    flush = 1'b0;
    winc  = 1'b0;
    rinc  = 1'b0;
    total += 4;
    if (s_level !== 3'd0)  begin bad++; $display("FAIL flush_level: got %0d want 0", s_level); end
    if ({s_rempty, s_wfull} !== 2'b10) begin bad++; $display("FAIL flush_flags: got %b want 10", {s_rempty, s_wfull}); end
    if ({s_walmost_full, s_ralmost_empty} !== 2'b01)
                           begin bad++; $display("FAIL flush_almost: got %b want 01", {s_walmost_full, s_ralmost_empty}); end
    if (s_rdata !== 32'hC9) begin bad++; $display("FAIL flush_rdata_hold: got %h want c9", s_rdata); end
    winc  = 1'b1;
    wdata = 32'h55;
    step();
    winc  = 1'b0;
    total += 1;
    if (f_rdata !== 32'h55) begin bad++; $display("FAIL post_flush_head: got %h want 55", f_rdata); end
    rinc = 1'b1;
    step();
    rinc = 1'b0;
    total += 2;
    if (s_rdata !== 32'h55) begin bad++; $display("FAIL post_flush_rdata: got %h want 55", s_rdata); end
    if (s_rempty !== 1'b1)  begin bad++; $display("FAIL post_flush_rempty: got %b want 1", s_rempty); end
  endtask

  task automatic test_err_flags();
`ifdef FIFO_ERR_FLAGS_EN
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    total += 1;
    if ({s_overflow, s_underflow} !== 2'b00) begin bad++; $display("FAIL err_clear0: got %b want 00", {s_overflow, s_underflow}); end
    rinc = 1'b1;
    step();
    rinc = 1'b0;
    total += 1;
    if ({s_overflow, s_underflow} !== 2'b01) begin bad++; $display("FAIL err_underflow: got %b want 01", {s_overflow, s_underflow}); end
    winc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wdata = 32'hE0 + i;
      step();
    end
    winc = 1'b0;
    total += 1;
    if ({s_overflow, s_underflow} !== 2'b11) begin bad++; $display("FAIL err_overflow: got %b want 11", {s_overflow, s_underflow}); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    total += 2;
    if ({s_overflow, s_underflow} !== 2'b11) begin bad++; $display("FAIL err_after_flush: got %b want 11", {s_overflow, s_underflow}); end
    if (s_level !== 3'd0) begin bad++; $display("FAIL err_flush_level: got %0d want 0", s_level); end
    // clr_err wins over a same-cycle underflow attempt.
    clr_err = 1'b1;
    rinc    = 1'b1;
    step();
    clr_err = 1'b0;
    rinc    = 1'b0;
    total += 1;
    if ({s_overflow, s_underflow} !== 2'b00) begin bad++; $display("FAIL err_clr: got %b want 00", {s_overflow, s_underflow}); end
    // Leave both flags set so the reset test shows rst clearing them.
    rinc = 1'b1;
    step();
    rinc = 1'b0;
    winc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wdata = 32'hF0 + i;
      step();
    end
    winc = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
`else
    rinc = 1'b1;
    step();
    rinc = 1'b0;
    winc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wdata = 32'hE0 + i;
      step();
    end
    winc = 1'b0;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    total += 2;
    if ({s_overflow, s_underflow} !== 2'b00) begin bad++; $display("FAIL err_tied_low: got %b want 00", {s_overflow, s_underflow}); end
    if (s_level !== 3'd4) begin bad++; $display("FAIL err_full_level: got %0d want 4", s_level); end
    flush = 1'b1;
    step();
    flush = 1'b0;
`endif
  endtask

  task automatic test_reset_mid_burst();
    winc = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wdata = 32'h70 + i;
      step();
    end
    rinc = 1'b1;
    step();
    // Assert reset mid-cycle; flops must clear without waiting for an edge.
    #2 rst = 1'b1;
    #1;
    total += 5;
    if (s_level !== 3'd0)   begin bad++; $display("FAIL rst_mid_level: got %0d want 0", s_level); end
    if ({s_rempty, s_wfull} !== 2'b10) begin bad++; $display("FAIL rst_mid_flags: got %b want 10", {s_rempty, s_wfull}); end
    if ({s_walmost_full, s_ralmost_empty} !== 2'b01)
                            begin bad++; $display("FAIL rst_mid_almost: got %b want 01", {s_walmost_full, s_ralmost_empty}); end
    if (s_rdata !== 32'h0)  begin bad++; $display("FAIL rst_mid_rdata: got %h want 0", s_rdata); end
    if ({s_overflow, s_underflow} !== 2'b00)
                            begin bad++; $display("FAIL rst_mid_err: got %b want 00", {s_overflow, s_underflow}); end
    winc = 1'b0;
    rinc = 1'b0;
    step();
    rst = 1'b0;
    step();
    total += 1;
    if (s_level !== 3'd0)   begin bad++; $display("FAIL rst_release_level: got %0d want 0", s_level); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain_std();
    test_fwft();
    test_back_to_back();
    test_flush();
    test_err_flags();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_sync_fwft.md
Name: fifo_sync_fwft

Overview:
- Single-clock successor to the dual-clock bridge FIFO, for AXI-Lite/APB paths that share one clock (APB response buffer, AXI write-data skid).
- Generalised in data width, depth and read mode: standard read or first-word-fall-through (FWFT).
- Adds occupancy level, programmable almost-full/almost-empty thresholds and synchronous flush.
- Pointer synchronisation is not needed, so flags have no CDC latency.

Parameters:
- DSIZE, 32, data word width in bits.
- ASIZE, 4, address width; DEPTH = 1<<ASIZE entries (ASIZE >= 1).
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.
- AFULL_THR, DEPTH-2, walmost_full asserts when level >= AFULL_THR (1..DEPTH).
- AEMPTY_THR, 1, ralmost_empty asserts when level <= AEMPTY_THR (0..DEPTH-1).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- flush  input  1  synchronous clear of contents.
- wdata  input  DSIZE  write data.
- winc  input  1  write request.
- wfull  output  1  full flag.
- walmost_full  output  1  level >= AFULL_THR.
- rinc  input  1  read request (pop).
- rdata  output  DSIZE  read data.
- rempty  output  1  empty flag (FWFT: no valid word on rdata).
- ralmost_empty  output  1  level <= AEMPTY_THR.
- level  output  ASIZE+1  stored word count, 0..DEPTH.
- overflow  output  1  sticky error (FIFO_ERR_FLAGS_EN only).
- underflow  output  1  sticky error (FIFO_ERR_FLAGS_EN only).
- clr_err  input  1  clears sticky errors (FIFO_ERR_FLAGS_EN only).

Behaviour:
- Reset (rst=1, async): wbin=rbin=0, level=0, rempty=1, wfull=0, walmost_full=0, ralmost_empty=1, rdata=0, overflow=underflow=0. Memory contents are not reset.
- Accepted write: wr_ok = winc & ~wfull. Accepted read: rd_ok = rinc & ~rempty. Both evaluate against registered flags.
- Pointers: binary, ASIZE+1 bits, wrap modulo 2*DEPTH; the address is the low ASIZE bits.
- Level next = level + wr_ok - rd_ok. Simultaneous wr_ok and rd_ok leave level unchanged.
- All flags are registered from the next-state level:
  - wfull = (level==DEPTH)
  - rempty = (level==0)
  - walmost_full = (level >= AFULL_THR)
  - ralmost_empty = (level <= AEMPTY_THR)
- Full: a write while wfull=1 is dropped and memory is unchanged, even when a read occurs in the same cycle.
- Empty: a read while rempty=1 is ignored; rdata holds.
- Write latency: word written at edge N gives rempty=0 after edge N; a read is possible from cycle N+1.
- FWFT=0: on rd_ok at edge N, rdata takes mem[raddr] after edge N. rdata holds otherwise.
- FWFT=1: while rempty=0, rdata presents the head word combinationally from the registered read pointer. rinc pops it, and the next word (if any) appears after the edge.
- Write-through at a same-address read/write: a read of an entry written in the same cycle is impossible, because level gating forbids it.
- Flush: at the next edge, pointers and level go to 0 and flags return to their reset values. rdata is held in FWFT=0; in FWFT=1 it is don't-care while rempty=1.
- Flush priority: flush beats winc/rinc in the same cycle, so neither is accepted. Sticky error flags are unaffected by flush.
- Wrap-around: continuous operation past 2*DEPTH writes must preserve order and level.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- When defined:
  - overflow is set after an edge where winc & wfull.
  - underflow is set after an edge where rinc & rempty.
  - Both hold until clr_err=1 at an edge or rst. clr_err has priority over a same-cycle set.
- When undefined: overflow and underflow are tied 0, clr_err is ignored, and no error registers are built.

Decomposition:
- Shared package fifo_pkg:
  - localparam helper function for DEPTH from ASIZE.
  - typedef for level width.
  - enum fifo_mode_e {FIFO_STD, FIFO_FWFT} mapped to the FWFT parameter.
- One sub-module, fifo_ram_2p: DEPTH x DSIZE, one synchronous write port and one asynchronous read port. The top block builds the registered (FWFT=0) or direct (FWFT=1) output around it.

Test Plan (DSIZE=32, ASIZE=2, DEPTH=4, AFULL_THR=3, AEMPTY_THR=1):
- Reset then write 0xA0..0xA3 on 4 consecutive cycles -> level 1,2,3,4; walmost_full at level 3; wfull=1 after the 4th edge; ralmost_empty drops at level 2.
- While full, winc with 0xFF -> level stays 4, memory unchanged. Then drain with FWFT=0 -> rdata 0xA0,0xA1,0xA2,0xA3 one cycle after each rinc; rempty=1 after the last pop.
- FWFT=1: write 0x11 at edge N -> rempty=0 and rdata=0x11 in cycle N+1 with no rinc. rinc -> rempty=1.
- Level 2 with winc and rinc in the same cycle, repeated 10 times (pointer wrap) -> level stays 2 and data order is intact.
- Level 3 with flush, winc and rinc together -> after the edge level=0, rempty=1, wfull=0; the written word never appears.
- FIFO_ERR_FLAGS_EN: rinc at empty -> underflow=1. winc at full -> overflow=1. Flush -> both stay 1. clr_err -> both 0. Assert rst mid-burst -> all outputs at reset values immediately.
